// File: rtl/sd_cmd_serial_host_pkg.sv
// Shared definitions for the SD CMD-line engine.
// Holds the response-type codes, the FSM state type, the CRC7 polynomial,
// the frame-length constants and a single-bit CRC7 update helper.
package sd_cmd_serial_host_pkg;

    typedef enum logic [1:0] {
        RSP_NONE     = 2'b00,  // no response expected
        RSP_48       = 2'b01,  // 48-bit response, CRC checked
        RSP_136      = 2'b10,  // 136-bit response (CID/CSD), CRC checked
        RSP_48_NOCRC = 2'b11   // 48-bit response, CRC field ignored (R3)
    } rsp_type_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_WAIT,
        ST_RX,
        ST_GAP
    } state_t;

    // x^7 + x^3 + 1
    localparam logic [6:0] CRC7_POLY = 7'h09;

    // Command frame: 40 CRC-covered bits, 7 CRC bits, end bit.
    localparam logic [7:0] TX_DATA_BITS = 8'd40;
    localparam logic [7:0] TX_END_IDX   = 8'd47;

    // Index (counted from the bit after the start bit) of the response end bit.
    localparam logic [7:0] RX_LAST_48  = 8'd46;
    localparam logic [7:0] RX_LAST_136 = 8'd134;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bitval);
        logic fb;
        fb = bitval ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_cmd_serial_host_if.sv
// Command/response handshake between the SD controller command FSM (master)
// and the CMD-line engine (slave).
//   cmd_start/cmd_index/cmd_arg/rsp_type : command request, master -> slave
//   busy/done                            : transaction status, slave -> master
//   rsp/crc_err/timeout                  : response payload and flags, valid at done
interface sd_cmd_serial_host_if;

    logic         cmd_start;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_arg;
    logic [1:0]   rsp_type;
    logic         busy;
    logic         done;
    logic [127:0] rsp;
    logic         crc_err;
    logic         timeout;

    modport master (
        output cmd_start, cmd_index, cmd_arg, rsp_type,
        input  busy, done, rsp, crc_err, timeout
    );

    modport slave (
        input  cmd_start, cmd_index, cmd_arg, rsp_type,
        output busy, done, rsp, crc_err, timeout
    );

endinterface

// File: rtl/sd_cmd_serial_host_crc7.sv
// Serial CRC7 generator/checker (x^7+x^3+1, initial value 0).
//   clk, rst_n : system clock, asynchronous active-low reset
//   clr        : restart the CRC from zero
//   en         : absorb bitval this cycle
//   bitval     : serial data bit, MSB first
//   crc        : current remainder
// clr together with en restarts from zero and absorbs bitval in the same cycle.
module sd_crc7
    import sd_cmd_serial_host_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       bitval,
    output logic [6:0] crc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (clr && en) begin
            crc <= crc7_step(7'h00, bitval);
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc7_step(crc, bitval);
        end
    end

endmodule

// File: rtl/sd_cmd_serial_host.sv
// SD CMD-line engine. Serialises a 48-bit command with CRC7 onto the CMD pad,
// waits for the card's start bit, deserialises a 48- or 136-bit response and
// checks its CRC7 and end bit. SD_CLK is sampled as a level in the CLK domain.
//   clk, rst_n      : system clock, asynchronous active-low reset
//   sd_clk          : divided SD clock, edge-detected, never used as a clock
//   cmd_in          : CMD pad input, sampled on SD_CLK rise
//   cmd_out, cmd_oe : CMD pad output data / enable, updated on SD_CLK fall
//   bus             : command request and response handshake (slave side)
module sd_cmd_serial_host
    import sd_cmd_serial_host_pkg::*;
#(
    parameter int unsigned NCR_MAX = 64,
    parameter int unsigned NCC     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sd_clk,
    input  logic                 cmd_in,
    output logic                 cmd_out,
    output logic                 cmd_oe,
    sd_cmd_serial_host_if.slave  bus
);

    localparam int unsigned NCR_W = $clog2(NCR_MAX + 1);
    localparam int unsigned GAP_W = $clog2(NCC + 1);

    state_t           state;
    rsp_type_t        rtype;
    logic             sdclk_q;
    logic             rise;
    logic             fall;
    logic [39:0]      tx_sr;
    logic [7:0]       bitcnt;
    logic [NCR_W-1:0] ncr;
    logic [GAP_W-1:0] gapcnt;
    logic [7:0]       rx_last;
    logic             rx_feed;
    logic             crc_clr;
    logic             crc_en;
    logic             crc_bit;
    logic [6:0]       crc;

    assign rise    = sd_clk & ~sdclk_q;
    assign fall    = ~sd_clk & sdclk_q;
    assign rx_last = (rtype == RSP_136) ? RX_LAST_136 : RX_LAST_48;

    // 48-bit: start bit (fed on entry to RX) plus the next 39 bits.
    // 136-bit: skip the 7 header bits after the start bit, then 120 payload bits.
    assign rx_feed = (rtype == RSP_136) ? (bitcnt >= 8'd7 && bitcnt < 8'd127)
                                        : (bitcnt < 8'd39);

    // The CRC engine is shared: TX and RX never overlap, so steer it by state.
    always_comb begin
        crc_clr = 1'b0;
        crc_en  = 1'b0;
        crc_bit = 1'b0;
        case (state)
            ST_IDLE: crc_clr = bus.cmd_start;
            ST_TX: begin
                crc_en  = fall && (bitcnt < TX_DATA_BITS);
                crc_bit = tx_sr[39];
            end
            ST_WAIT: begin
                crc_clr = rise && !cmd_in;
                crc_en  = rise && !cmd_in;
            end
            ST_RX: begin
                crc_en  = rise && rx_feed;
                crc_bit = cmd_in;
            end
            default: ;
        endcase
    end

    sd_crc7 u_crc7 (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (crc_clr),
        .en     (crc_en),
        .bitval (crc_bit),
        .crc    (crc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rtype       <= RSP_NONE;
            sdclk_q     <= 1'b0;
            tx_sr       <= '0;
            bitcnt      <= '0;
            ncr         <= '0;
            gapcnt      <= '0;
            cmd_out     <= 1'b1;
            cmd_oe      <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.rsp     <= '0;
            bus.crc_err <= 1'b0;
            bus.timeout <= 1'b0;
        end else begin
            sdclk_q  <= sd_clk;
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_start) begin
                        tx_sr       <= {1'b0, 1'b1, bus.cmd_index, bus.cmd_arg};
                        rtype       <= rsp_type_t'(bus.rsp_type);
                        bus.rsp     <= '0;
                        bus.crc_err <= 1'b0;
                        bus.timeout <= 1'b0;
                        bus.busy    <= 1'b1;
                        bitcnt      <= '0;
                        state       <= ST_TX;
                    end
                end
                ST_TX: begin
                    if (fall) begin
                        if (bitcnt < TX_DATA_BITS) begin
                            cmd_out <= tx_sr[39];
                            cmd_oe  <= 1'b1;
                            tx_sr   <= {tx_sr[38:0], 1'b0};
                            bitcnt  <= bitcnt + 8'd1;
                        end else if (bitcnt < TX_END_IDX) begin
                            // bitcnt 40..46 -> crc[6]..crc[0]
                            cmd_out <= crc[3'd6 - bitcnt[2:0]];
                            bitcnt  <= bitcnt + 8'd1;
                        end else if (bitcnt == TX_END_IDX) begin
                            cmd_out <= 1'b1;
                            bitcnt  <= bitcnt + 8'd1;
                        end else begin
                            cmd_oe  <= 1'b0;
                            cmd_out <= 1'b1;
                            bitcnt  <= '0;
                            ncr     <= '0;
                            gapcnt  <= '0;
                            state   <= (rtype == RSP_NONE) ? ST_GAP : ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (rise) begin
                        if (!cmd_in) begin
                            bitcnt <= '0;
                            state  <= ST_RX;
                        end else if (ncr == NCR_W'(NCR_MAX - 1)) begin
                            bus.timeout <= 1'b1;
                            gapcnt      <= '0;
                            state       <= ST_GAP;
                        end else begin
                            ncr <= ncr + 1'b1;
                        end
                    end
                end
                ST_RX: begin
                    if (rise) begin
                        bus.rsp <= {bus.rsp[126:0], cmd_in};
                        if (bitcnt == rx_last) begin
                            // rsp[6:0] still holds the received CRC7 before this shift.
                            bus.crc_err <= ~cmd_in |
                                           ((rtype != RSP_48_NOCRC) && (crc != bus.rsp[6:0]));
                            gapcnt      <= '0;
                            state       <= ST_GAP;
                        end else begin
                            bitcnt <= bitcnt + 8'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (rise) begin
                        if (gapcnt == GAP_W'(NCC - 1)) begin
                            bus.done <= 1'b1;
                            bus.busy <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            gapcnt <= gapcnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_serial_host.sv
// Self-checking bench for sd_cmd_serial_host. SD_CLK is CLK/2 (divider 1).
// A card model drives CMD_IN per SD_CLK rise; TX frames and response results
// are checked against expectations queued when each command is issued.
module tb_sd_cmd_serial_host;

    localparam int unsigned NCR_MAX = 64;
    localparam int unsigned NCC     = 8;

    typedef struct packed {
        logic [127:0] rsp;
        logic         crc_err;
        logic         timeout;
    } res_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic sd_clk = 1'b0;
    logic cmd_in = 1'b1;
    logic cmd_out;
    logic cmd_oe;

    sd_cmd_serial_host_if bus();

    sd_cmd_serial_host #(.NCR_MAX(NCR_MAX), .NCC(NCC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sd_clk  (sd_clk),
        .cmd_in  (cmd_in),
        .cmd_out (cmd_out),
        .cmd_oe  (cmd_oe),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) sd_clk <= ~sd_clk;

    int errors = 0;
    int checks = 0;

    logic [47:0] tx_q[$];
    res_t        res_q[$];

    // card / monitor state
    logic         sd_prev = 1'b0;
    logic         oe_prev = 1'b0;
    int           rise_cnt = 0;
    int           rel_mark = 0;
    logic         card_en = 1'b0;
    logic         card_active = 1'b0;
    logic [135:0] card_fr = '0;
    int           card_len = 48;
    logic [47:0]  tx_sh = '0;
    int           tx_n = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] crc7_calc(input logic [135:0] data, input int n);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = n - 1; i >= 0; i--) begin
            fb = data[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [127:0] r48(input logic [47:0] f);
        logic [127:0] v;
        v = '0;
        v[46:0] = f[46:0];
        return v;
    endfunction

    // All sampling and card driving happens on the falling CLK edge, well away
    // from the edges where SD_CLK and the DUT outputs change.
    always @(negedge clk) begin
        logic       rise;
        int         r;
        logic [47:0] e;
        rise    = sd_clk && !sd_prev;
        sd_prev = sd_clk;
        if (oe_prev && !cmd_oe) begin
            rel_mark    = rise_cnt;
            card_active = card_en;
        end
        oe_prev = cmd_oe;
        if (!rst_n) tx_n = 0;
        if (rise) begin
            rise_cnt++;
            if (cmd_oe && rst_n) begin
                tx_sh = {tx_sh[46:0], cmd_out};
                tx_n++;
                if (tx_n == 48) begin
                    tx_n = 0;
                    e = 'x;
                    if (tx_q.size() > 0) e = tx_q.pop_front();
                    chk("tx_frame", tx_sh, e);
                end
            end
            r = rise_cnt - rel_mark;
            if (card_active && r > 5 && r <= 5 + card_len)
                cmd_in = card_fr[card_len - 1 - (r - 6)];
            else
                cmd_in = 1'b1;
        end
    end

    task automatic run_cmd(input string name, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [1:0] rt, input logic reply, input logic [135:0] cfr,
                           input int clen, input logic [47:0] exp_tx, input logic [127:0] exp_rsp,
                           input logic exp_crc, input logic exp_to, input int exp_rises,
                           input logic poke);
        int   lat;
        int   n;
        res_t got;
        res_t exp;
        tx_q.push_back(exp_tx);
        res_q.push_back('{exp_rsp, exp_crc, exp_to});
        card_en  = reply;
        card_fr  = cfr;
        card_len = clen;
        @(negedge clk);
        bus.cmd_start = 1'b1;
        bus.cmd_index = idx;
        bus.cmd_arg   = arg;
        bus.rsp_type  = rt;
        @(negedge clk);
        bus.cmd_start = 1'b0;
        chk({name, "_busy_set"}, bus.busy, 1'b1);
        lat = 0;
        while (!cmd_oe && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_oe_latency_ok"}, lat <= 3, 1'b1);
        if (poke) begin
            repeat (10) @(negedge clk);
            bus.cmd_start = 1'b1;
            bus.cmd_index = 6'h3F;
            bus.cmd_arg   = '1;
            @(negedge clk);
            bus.cmd_start = 1'b0;
        end
        n = 0;
        while (!bus.done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done_seen"}, bus.done, 1'b1);
        chk({name, "_busy_clr"}, bus.busy, 1'b0);
        got = '{bus.rsp, bus.crc_err, bus.timeout};
        exp = res_q.pop_front();
        chk({name, "_rsp"}, got.rsp, exp.rsp);
        chk({name, "_crc_err"}, got.crc_err, exp.crc_err);
        chk({name, "_timeout"}, got.timeout, exp.timeout);
        if (exp_rises >= 0) chk({name, "_rises"}, rise_cnt - rel_mark, exp_rises);
        card_en     = 1'b0;
        card_active = 1'b0;
        @(negedge clk);
        chk({name, "_done_pulse"}, bus.done, 1'b0);
    endtask

    initial begin
        logic [47:0]  c8;
        logic [47:0]  c17;
        logic [47:0]  c17_bad;
        logic [39:0]  txd;
        logic [47:0]  tx2;
        logic [47:0]  tx41;
        logic [127:0] pay;
        logic [6:0]   pc;
        logic [135:0] r2;
        int           n;

        bus.cmd_start = 1'b0;
        bus.cmd_index = '0;
        bus.cmd_arg   = '0;
        bus.rsp_type  = 2'b00;

        repeat (4) @(negedge clk);
        chk("rst_cmd_out", cmd_out, 1'b1);
        chk("rst_cmd_oe", cmd_oe, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_rsp", bus.rsp, '0);
        chk("rst_crc_err", bus.crc_err, 1'b0);
        chk("rst_timeout", bus.timeout, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        c8      = 48'h08000001AA13;
        c17     = 48'h110000090067;
        c17_bad = c17 ^ (48'h1 << 8);

        run_cmd("cmd0", 6'd0, 32'h0, 2'b00, 1'b0, '0, 48, 48'h400000000095,
                '0, 1'b0, 1'b0, NCC, 1'b0);
        run_cmd("cmd8", 6'd8, 32'h1AA, 2'b01, 1'b1, {88'b0, c8}, 48, 48'h48000001AA87,
                r48(c8), 1'b0, 1'b0, -1, 1'b0);
        run_cmd("cmd17", 6'd17, 32'h0, 2'b01, 1'b1, {88'b0, c17}, 48, 48'h510000000055,
                r48(c17), 1'b0, 1'b0, -1, 1'b0);
        run_cmd("cmd17_bad", 6'd17, 32'h0, 2'b01, 1'b1, {88'b0, c17_bad}, 48, 48'h510000000055,
                r48(c17_bad), 1'b1, 1'b0, -1, 1'b0);
        run_cmd("tmo", 6'd17, 32'h0, 2'b01, 1'b0, '0, 48, 48'h510000000055,
                '0, 1'b0, 1'b1, NCR_MAX + NCC, 1'b0);

        // R3: CRC field all ones, ignored; end bit good.
        txd  = {2'b01, 6'd41, 32'h40300000};
        tx41 = {txd, crc7_calc({96'b0, txd}, 40), 1'b1};
        run_cmd("r3", 6'd41, 32'h40300000, 2'b11, 1'b1, {88'b0, 48'h3F00FF8000FF}, 48, tx41,
                r48(48'h3F00FF8000FF), 1'b0, 1'b0, -1, 1'b0);

        // R2: 136-bit response with random CID payload.
        txd = {2'b01, 6'd2, 32'h0};
        tx2 = {txd, crc7_calc({96'b0, txd}, 40), 1'b1};
        pay = {$urandom, $urandom, $urandom, $urandom};
        pc  = crc7_calc({16'b0, pay[119:0]}, 120);
        r2  = {2'b00, 6'h3F, pay[119:0], pc, 1'b1};
        run_cmd("r2", 6'd2, 32'h0, 2'b10, 1'b1, r2, 136, tx2,
                r2[127:0], 1'b0, 1'b0, -1, 1'b0);

        // Reset in the middle of a command frame.
        @(negedge clk);
        bus.cmd_start = 1'b1;
        bus.cmd_index = 6'd17;
        bus.cmd_arg   = 32'h0;
        bus.rsp_type  = 2'b00;
        @(negedge clk);
        bus.cmd_start = 1'b0;
        n = 0;
        while (tx_n < 20 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_bit20", tx_n, 20);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cmd_oe", cmd_oe, 1'b0);
        chk("abort_cmd_out", cmd_out, 1'b1);
        chk("abort_busy", bus.busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fresh command after reset, with a CMD_START pulsed while busy.
        run_cmd("cmd8_after_rst", 6'd8, 32'h1AA, 2'b01, 1'b1, {88'b0, c8}, 48, 48'h48000001AA87,
                r48(c8), 1'b0, 1'b0, -1, 1'b1);
        repeat (150) @(negedge clk);
        chk("idle_after_poke", bus.busy, 1'b0);
        chk("tx_queue_drained", tx_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
